bs_job_scheduler: RTL and testbench
===================================

BS_JOB_SCHEDULER -- requirements
Module: bs_job_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, 16, width of every price/parameter word.
REQ-002 SHALL have parameter TIMEOUT_CYC, 1024, maximum RUN cycles before a job is aborted (used only with BS_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester has a job.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  job accepted this cycle when ready and valid are both high.
REQ-007 SHALL have ports req0_params / req1_params  input  5*DATA_W  job parameters, packed {T,sigma,r,K,S} with S in the LSBs.
REQ-008 SHALL have port core_start  output  1  start to the Black-Scholes core, held until done.
REQ-009 SHALL have ports core_S, core_K, core_r, core_sigma, core_T  output  DATA_W each  registered job parameters to the core.
REQ-010 SHALL have port core_done  input  1  core result valid.
REQ-011 SHALL have port core_call_price  input  DATA_W  core result.
REQ-012 SHALL have port rsp_valid  output  1  result available.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-014 SHALL have port rsp_id  output  1  requester index that owns the result.
REQ-015 SHALL have ports rsp_price (output, DATA_W) and rsp_err (output, 1)  result price and timeout flag.
REQ-016 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-017 SHALL have port job_cnt  output  16  count of completed responses; wraps 0xFFFF->0.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and RESP.
REQ-019 SHALL assert reqN_ready only in IDLE, only for the arbitration winner, and combinationally from valid.
REQ-020 SHALL arbitrate round-robin: a sole valid requester wins; with both valid, the requester not granted last wins.
REQ-021 On accept in IDLE SHALL latch params into core_*, record rsp_id and the grant, and move to RUN, so core_start is high from the next cycle.
REQ-022 SHALL hold core_start high throughout RUN and sample core_done only in RUN; core_done in IDLE or RESP is ignored.
REQ-023 On core_done in RUN SHALL capture core_call_price into rsp_price, set rsp_err=0, drive core_start low and rsp_valid high next cycle, and move to RESP (1-cycle latency done->rsp_valid).
REQ-024 SHALL hold rsp_valid, rsp_id, rsp_price and rsp_err stable in RESP until rsp_ready is high.
REQ-025 On the RESP handshake SHALL increment job_cnt and return to IDLE, so a new accept is possible in the following cycle.
REQ-026 SHALL guarantee core_start is low for at least one cycle between consecutive jobs.
REQ-027 SHALL keep core_* outputs unchanged from accept until the next accept.

Reset
REQ-028 While rst_n is low SHALL immediately force state=IDLE; core_start, rsp_valid, rsp_id, rsp_err, busy = 0; rsp_price, core_*, job_cnt = 0; last grant = requester 1 so requester 0 wins first.
REQ-029 A reset in RUN or RESP SHALL abandon the job silently with no response.

Configuration
REQ-030 With BS_TIMEOUT_EN defined, SHALL count RUN cycles; when TIMEOUT_CYC cycles elapse without core_done, SHALL drop core_start, enter RESP with rsp_err=1 and rsp_price=0, and clear the counter on every RUN entry.
REQ-031 With BS_TIMEOUT_EN undefined, SHALL omit the counter, wait in RUN indefinitely, and tie rsp_err to 0.

Structure
REQ-032 SHALL place DATA_W, the parameter-packing field offsets and the FSM state typedef in the shared package bs_pkg.
REQ-033 SHALL implement arbitration in sub-module bs_rr_arb2 (2 requests, last-grant pointer, grant one-hot).

Verification
REQ-034 Single job: req0 with S=0x6400, K=0x5F00 -> core_S=0x6400 and core_start high 1 cycle after accept; core_done with price 0x0A3C -> rsp_valid next cycle with rsp_id=0 and rsp_price=0x0A3C.
REQ-035 Contention: both valid out of reset for 4 jobs each -> grant order 0,1,0,1,...; core_start low at least 1 cycle between jobs.
REQ-036 Backpressure: rsp_ready low for 10 cycles -> response stable, both readys low, busy=1, and job_cnt increments only at the handshake.
REQ-037 Timeout (BS_TIMEOUT_EN, TIMEOUT_CYC=16): core_done never asserted -> rsp_err=1 and rsp_price=0 after 16 RUN cycles, core_start low; without the macro -> still in RUN after 10000 cycles.
REQ-038 Reset mid-RUN: deassert rst_n for 1 cycle -> core_start and busy go low immediately, no rsp_valid, and the next job from requester 0 completes normally.
REQ-039 Spurious done: core_done pulsed in IDLE -> no response and job_cnt unchanged.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared definitions for the Black-Scholes job scheduler: data width,
// parameter-packing field layout and FSM state encoding.
package bs_pkg;

    localparam int DATA_W = 16;

    // Field indices inside the packed {T,sigma,r,K,S} parameter word.
    localparam int FLD_S     = 0;
    localparam int FLD_K     = 1;
    localparam int FLD_R     = 2;
    localparam int FLD_SIGMA = 3;
    localparam int FLD_T     = 4;
    localparam int NUM_FLD   = 5;

    function automatic int fld_lo(input int fld, input int w);
        return fld * w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } bs_state_e;

endpackage

// File: rtl/bs_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, on contention the
// requester that was not granted last wins. Pointer resets to requester 1.
module bs_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
    end

    always_comb begin
        last_d = last_q;
        if (upd_i && (gnt_o != 2'b00)) last_d = gnt_o[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/bs_job_scheduler.sv
// Feeds jobs from two requesters into a single Black-Scholes core and returns
// tagged results. Optional RUN watchdog enabled by defining BS_TIMEOUT_EN.
module bs_job_scheduler #(
    parameter int DATA_W      = bs_pkg::DATA_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req0_valid,
    input  logic                           req1_valid,
    output logic                           req0_ready,
    output logic                           req1_ready,
    input  logic [bs_pkg::NUM_FLD*DATA_W-1:0] req0_params,
    input  logic [bs_pkg::NUM_FLD*DATA_W-1:0] req1_params,
    output logic                           core_start,
    output logic [DATA_W-1:0]              core_S,
    output logic [DATA_W-1:0]              core_K,
    output logic [DATA_W-1:0]              core_r,
    output logic [DATA_W-1:0]              core_sigma,
    output logic [DATA_W-1:0]              core_T,
    input  logic                           core_done,
    input  logic [DATA_W-1:0]              core_call_price,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_id,
    output logic [DATA_W-1:0]              rsp_price,
    output logic                           rsp_err,
    output logic                           busy,
    output logic [15:0]                    job_cnt
);

    import bs_pkg::*;

    localparam int PW = NUM_FLD * DATA_W;

    bs_state_e         state_q, state_d;
    logic [1:0]        gnt;
    logic              accept;
    logic              tmo_hit;
    logic [PW-1:0]     params_q;
    logic [PW-1:0]     params_sel;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_price_q;
    logic [15:0]       job_cnt_q;

    // Arbiter only sees requests in IDLE so the pointer moves on accepts only.
    bs_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({req1_valid, req0_valid} & {2{state_q == ST_IDLE}}),
        .upd_i (accept),
        .gnt_o (gnt)
    );

    assign accept     = (state_q == ST_IDLE) && (gnt != 2'b00);
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign params_sel = gnt[1] ? req1_params : req0_params;

`ifdef BS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          rsp_err_q;

    assign tmo_hit = (state_q == ST_RUN) && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign rsp_err = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept)                 tmo_cnt_q <= '0;
            else if (state_q == ST_RUN) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (state_q == ST_RUN && core_done) rsp_err_q <= 1'b0;
            else if (tmo_hit)                   rsp_err_q <= 1'b1;
        end
    end
`else
    // Watchdog compiled out: RUN only ends on core_done.
    assign tmo_hit = (TIMEOUT_CYC < 0);
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)               state_d = ST_RUN;
            ST_RUN:  if (core_done || tmo_hit) state_d = ST_RESP;
            ST_RESP: if (rsp_ready)            state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            params_q    <= '0;
            rsp_id_q    <= 1'b0;
            rsp_price_q <= '0;
            job_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                params_q <= params_sel;
                rsp_id_q <= gnt[1];
            end
            if (state_q == ST_RUN && core_done) rsp_price_q <= core_call_price;
            else if (tmo_hit)                   rsp_price_q <= '0;
            if (state_q == ST_RESP && rsp_ready) job_cnt_q <= job_cnt_q + 16'd1;
        end
    end

    assign core_start = (state_q == ST_RUN);
    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_price  = rsp_price_q;
    assign job_cnt    = job_cnt_q;
    assign core_S     = params_q[fld_lo(FLD_S, DATA_W)     +: DATA_W];
    assign core_K     = params_q[fld_lo(FLD_K, DATA_W)     +: DATA_W];
    assign core_r     = params_q[fld_lo(FLD_R, DATA_W)     +: DATA_W];
    assign core_sigma = params_q[fld_lo(FLD_SIGMA, DATA_W) +: DATA_W];
    assign core_T     = params_q[fld_lo(FLD_T, DATA_W)     +: DATA_W];

endmodule

// File: tb/tb_bs_job_scheduler.sv
// Randomized bench for bs_job_scheduler against a transaction-level model
// (round-robin winner, latched parameters, response contents, job count).
module tb_bs_job_scheduler;

`ifdef BS_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clk, rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [79:0] req0_params, req1_params;
    logic        core_start, core_done;
    logic [15:0] core_S, core_K, core_r, core_sigma, core_T, core_call_price;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [15:0] rsp_price, job_cnt;

    bs_job_scheduler #(.DATA_W(16), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_params(req0_params), .req1_params(req1_params),
        .core_start(core_start),
        .core_S(core_S), .core_K(core_K), .core_r(core_r),
        .core_sigma(core_sigma), .core_T(core_T),
        .core_done(core_done), .core_call_price(core_call_price),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_price(rsp_price), .rsp_err(rsp_err),
        .busy(busy), .job_cnt(job_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_chk = 0, n_err = 0;
    bit        mdl_last;   // requester granted most recently
    bit [15:0] mdl_cnt;    // responses handed over so far

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [79:0] rnd_params();
        return {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    function automatic logic [79:0] core_vec();
        return {core_T, core_sigma, core_r, core_K, core_S};
    endfunction

    task automatic run_job(input bit v0, input bit v1, input logic [79:0] p0, input logic [79:0] p1,
                           input int dly, input logic [15:0] price, input int bp);
        bit          w;
        logic [79:0] pw;
        @(posedge clk); #1;
        req0_valid = v0; req1_valid = v1; req0_params = p0; req1_params = p1;
        w  = (v0 && v1) ? !mdl_last : !v0;
        pw = w ? p1 : p0;
        @(negedge clk);
        chk("req0_ready", req0_ready, !w);
        chk("req1_ready", req1_ready, w);
        chk("busy_idle", busy, 0);
        @(posedge clk); #1;
        if (w) req1_valid = 1'b0; else req0_valid = 1'b0;
        mdl_last = w;
        @(negedge clk);
        chk("start_after_accept", core_start, 1);
        chk("core_params", core_vec(), pw);
        chk("readys_run", {req1_ready, req0_ready}, 0);
        chk("busy_run", busy, 1);
        repeat (dly) begin
            @(negedge clk);
            chk("start_held", core_start, 1);
        end
        @(posedge clk); #1;
        core_done = 1'b1; core_call_price = price;
        @(posedge clk); #1;
        core_done = 1'b0; core_call_price = 16'($urandom);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, w);
        chk("rsp_price", rsp_price, price);
        chk("rsp_err", rsp_err, 0);
        chk("start_low_resp", core_start, 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_stable", {rsp_valid, rsp_id, rsp_price, rsp_err}, {1'b1, w, price, 1'b0});
            chk("bp_readys", {busy, req1_ready, req0_ready}, 3'b100);
            chk("bp_cnt", job_cnt, mdl_cnt);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        mdl_cnt++;
        @(negedge clk);
        chk("job_cnt", job_cnt, mdl_cnt);
        chk("idle_after_hs", {busy, rsp_valid, core_start}, 0);
        chk("core_params_held", core_vec(), pw);
    endtask

    task automatic start_stall_job();
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b0; req0_params = rnd_params();
        @(posedge clk); #1;
        req0_valid = 1'b0;
        mdl_last = 1'b0;
    endtask

    initial begin
        bit v0, v1;
        int r, n;
        rst_n = 1'b0; req0_valid = 0; req1_valid = 0; req0_params = '0; req1_params = '0;
        core_done = 0; core_call_price = '0; rsp_ready = 0;
        mdl_last = 1'b1; mdl_cnt = '0;
        #3;
        chk("rst_outs", {core_start, rsp_valid, rsp_id, rsp_err, busy}, 0);
        chk("rst_vals", {rsp_price, job_cnt, core_vec()}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single directed job
        run_job(1, 0, {16'h1111, 16'h2222, 16'h3333, 16'h5F00, 16'h6400}, '0, 2, 16'h0A3C, 0);

        // Contention: alternating grants
        for (int j = 0; j < 8; j++)
            run_job(1, 1, rnd_params(), rnd_params(), $urandom_range(0, 3), 16'($urandom), 0);

        // Backpressure
        run_job(0, 1, rnd_params(), rnd_params(), 1, 16'hBEEF, 10);

        // Spurious done in IDLE
        @(posedge clk); #1 core_done = 1'b1;
        @(posedge clk); #1 core_done = 1'b0;
        @(negedge clk);
        chk("spurious_rsp", rsp_valid, 0);
        chk("spurious_busy", busy, 0);
        chk("spurious_cnt", job_cnt, mdl_cnt);

        // Randomized jobs
        for (int j = 0; j < 20; j++) begin
            r  = $urandom_range(1, 3);
            v0 = r[0]; v1 = r[1];
            run_job(v0, v1, rnd_params(), rnd_params(), $urandom_range(0, 5),
                    16'($urandom), $urandom_range(0, 3));
        end

        start_stall_job();
`ifdef BS_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (core_start) n++;
        end
        chk("tmo_run_cycles", n, TMO);
        chk("tmo_rsp", {rsp_valid, rsp_err, rsp_price, core_start}, {1'b1, 1'b1, 16'h0, 1'b0});
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        mdl_cnt++;
        @(negedge clk);
        chk("tmo_cnt", job_cnt, mdl_cnt);
        start_stall_job();
        repeat (5) @(negedge clk);
`else
        n = 0;
        repeat (10000) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("hang_no_rsp", n, 0);
        chk("hang_still_run", {core_start, busy}, 2'b11);
`endif
        chk("pre_reset_run", core_start, 1);

        // Reset mid-RUN abandons the job
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rst_async", {core_start, busy, rsp_valid}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        mdl_last = 1'b1; mdl_cnt = '0;
        @(negedge clk);
        chk("post_rst", {rsp_valid, job_cnt}, 0);
        run_job(1, 1, rnd_params(), rnd_params(), 2, 16'h1234, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
